// File: rtl/core_issue_scoreboard.sv
// core_issue_scoreboard: issue-stage hazard controller.
// Tracks pending int (x1..x31) and FP (f0..f31) destination writes and stalls
// issue on RAW/WAW hazards, on the shared FDIV/FSQRT unit and on the
// in-flight limit. Writeback ports release tracked registers.
// Optional build macro: CORE_SB_WB_BYPASS_EN (same-cycle writeback relieves
// hazards and frees its in-flight slot for the current issue decision).
module core_issue_scoreboard #(
    parameter int MAX_INFLIGHT = 8,
    parameter int LONG_LAT     = 12
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_is_valid,
    output logic        o_is_ready,
    input  logic [4:0]  i_is_rs1,
    input  logic [4:0]  i_is_rs2,
    input  logic [4:0]  i_is_rd,
    input  logic [4:0]  i_is_frs1,
    input  logic [4:0]  i_is_frs2,
    input  logic [4:0]  i_is_frd,
    input  logic [2:0]  i_is_fen,
    input  logic        i_is_long,
    input  logic        i_wb_x_valid,
    input  logic [4:0]  i_wb_x_num,
    input  logic        i_wb_f_valid,
    input  logic [4:0]  i_wb_f_num,
    output logic [31:0] o_xbusy,
    output logic [31:0] o_fbusy,
    output logic [3:0]  o_inflight,
    output logic        o_long_busy,
    output logic [2:0]  o_stall_cause
);

    localparam int          CW        = (LONG_LAT > 2) ? $clog2(LONG_LAT) : 1;
    localparam logic [3:0]  MAX_C     = 4'(MAX_INFLIGHT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LONG_LAT - 1);

    typedef enum logic {L_IDLE, L_RUN} lstate_t;

    logic [31:0]   r_xbusy, r_fbusy;
    logic [3:0]    r_inflight;
    lstate_t       r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;

    logic          w_xwb_hit, w_fwb_hit;
    logic [31:0]   w_xclr, w_fclr, w_xset, w_fset;
    logic [31:0]   w_xchk, w_fchk;
    logic [1:0]    w_dec;
    logic [3:0]    w_slots;
    logic          w_raw, w_waw, w_struct, w_fire, w_has_dest;

    // Writeback only counts when it names a register that is actually tracked.
    always_comb begin
        w_xwb_hit = i_wb_x_valid && (i_wb_x_num != 5'd0) && r_xbusy[i_wb_x_num];
        w_fwb_hit = i_wb_f_valid && r_fbusy[i_wb_f_num];
        w_xclr    = w_xwb_hit ? (32'd1 << i_wb_x_num) : 32'd0;
        w_fclr    = w_fwb_hit ? (32'd1 << i_wb_f_num) : 32'd0;
        w_dec     = {1'b0, w_xwb_hit} + {1'b0, w_fwb_hit};
    end

    // Busy view used for hazard checks; bypass lets a same-cycle WB count as done.
    always_comb begin
`ifdef CORE_SB_WB_BYPASS_EN
        w_xchk  = r_xbusy & ~w_xclr;
        w_fchk  = r_fbusy & ~w_fclr;
        w_slots = r_inflight - {2'b00, w_dec};
`else
        w_xchk  = r_xbusy;
        w_fchk  = r_fbusy;
        w_slots = r_inflight;
`endif
    end

    // Hazard classification and issue handshake.
    always_comb begin
        w_raw = ((i_is_rs1 != 5'd0) && w_xchk[i_is_rs1])
              | ((i_is_rs2 != 5'd0) && w_xchk[i_is_rs2])
              | (i_is_fen[0] && w_fchk[i_is_frs1])
              | (i_is_fen[1] && w_fchk[i_is_frs2]);
        w_waw = ((i_is_rd != 5'd0) && w_xchk[i_is_rd])
              | (i_is_fen[2] && w_fchk[i_is_frd]);
        w_struct      = (w_slots == MAX_C) | (i_is_long & o_long_busy);
        o_stall_cause = {w_struct, w_waw, w_raw};
        o_is_ready    = ~i_flush & ~w_raw & ~w_waw & ~w_struct;
        w_fire        = i_is_valid & o_is_ready;
        w_has_dest    = (i_is_rd != 5'd0) | i_is_fen[2];
        w_xset        = (w_fire && (i_is_rd != 5'd0)) ? (32'd1 << i_is_rd) : 32'd0;
        w_fset        = (w_fire && i_is_fen[2]) ? (32'd1 << i_is_frd) : 32'd0;
    end

    // Busy maps and in-flight count; set wins over clear, flush wins over all.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_xbusy    <= '0;
            r_fbusy    <= '0;
            r_inflight <= '0;
        end else if (i_flush) begin
            r_xbusy    <= '0;
            r_fbusy    <= '0;
            r_inflight <= '0;
        end else begin
            r_xbusy    <= ((r_xbusy & ~w_xclr) | w_xset) & ~32'd1;
            r_fbusy    <= (r_fbusy & ~w_fclr) | w_fset;
            r_inflight <= r_inflight + {3'b000, w_fire & w_has_dest} - {2'b00, w_dec};
        end
    end

    // FDIV/FSQRT occupancy: next-state logic.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        case (r_state)
            L_IDLE: if (w_fire && i_is_long) begin
                w_state_n = L_RUN;
                w_cnt_n   = CNT_LOAD;
            end
            L_RUN: if (r_cnt == '0) w_state_n = L_IDLE;
                   else             w_cnt_n   = r_cnt - 1'b1;
            default: w_state_n = L_IDLE;
        endcase
        if (i_flush) begin
            w_state_n = L_IDLE;
            w_cnt_n   = '0;
        end
    end

    // FDIV/FSQRT occupancy: state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= L_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    assign o_xbusy     = r_xbusy;
    assign o_fbusy     = r_fbusy;
    assign o_inflight  = r_inflight;
    assign o_long_busy = (r_state == L_RUN);

`ifdef ASSERT
    // Writeback to an untracked register points at a bookkeeping bug upstream.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush) begin
            if (i_wb_x_valid && (i_wb_x_num != 5'd0) && !r_xbusy[i_wb_x_num])
                $error("int writeback to non-busy x%0d", i_wb_x_num);
            if (i_wb_f_valid && !r_fbusy[i_wb_f_num])
                $error("fp writeback to non-busy f%0d", i_wb_f_num);
        end
    end
`endif

endmodule

// File: tb/tb_core_issue_scoreboard.sv
// Directed bench for core_issue_scoreboard (default build, no WB bypass).
module tb_core_issue_scoreboard;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        is_valid, is_ready, is_long;
    logic [4:0]  rs1, rs2, rd, frs1, frs2, frd;
    logic [2:0]  fen;
    logic        wbx_v, wbf_v;
    logic [4:0]  wbx_n, wbf_n;
    logic [31:0] xbusy, fbusy;
    logic [3:0]  inflight;
    logic        long_busy;
    logic [2:0]  cause;

    int checks = 0;
    int errors = 0;

    core_issue_scoreboard #(.MAX_INFLIGHT(8), .LONG_LAT(12)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_is_valid(is_valid), .o_is_ready(is_ready),
        .i_is_rs1(rs1), .i_is_rs2(rs2), .i_is_rd(rd),
        .i_is_frs1(frs1), .i_is_frs2(frs2), .i_is_frd(frd),
        .i_is_fen(fen), .i_is_long(is_long),
        .i_wb_x_valid(wbx_v), .i_wb_x_num(wbx_n),
        .i_wb_f_valid(wbf_v), .i_wb_f_num(wbf_n),
        .o_xbusy(xbusy), .o_fbusy(fbusy), .o_inflight(inflight),
        .o_long_busy(long_busy), .o_stall_cause(cause)
    );

    always #5 clk = ~clk;

    task automatic idle_in();
        is_valid = 0; is_long = 0; rs1 = 0; rs2 = 0; rd = 0;
        frs1 = 0; frs2 = 0; frd = 0; fen = 0;
        wbx_v = 0; wbx_n = 0; wbf_v = 0; wbf_n = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic op(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                      input logic [4:0] f1, input logic [4:0] f2, input logic [4:0] fd,
                      input logic [2:0] en, input logic lg);
        is_valid = 1; rs1 = r1; rs2 = r2; rd = d;
        frs1 = f1; frs2 = f2; frd = fd; fen = en; is_long = lg;
    endtask

    task automatic do_flush();
        idle_in(); flush = 1; step(); flush = 0;
    endtask

    task automatic test_reset();
        idle_in(); #1;
        checks++; if (xbusy !== 32'd0) begin errors++; $display("FAIL reset_xbusy got %h want 0", xbusy); end
        checks++; if (fbusy !== 32'd0) begin errors++; $display("FAIL reset_fbusy got %h want 0", fbusy); end
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
        checks++; if (long_busy !== 1'b0) begin errors++; $display("FAIL reset_long_busy got %b want 0", long_busy); end
        checks++; if (is_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", is_ready); end
    endtask

    task automatic test_raw_waw();
        op(0, 0, 5, 0, 0, 0, 3'b000, 0); #1;
        checks++; if (is_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready got %b want 1", is_ready); end
        step();
        op(5, 0, 6, 0, 0, 0, 3'b000, 0); #1;
        checks++; if (xbusy[5] !== 1'b1 || inflight !== 4'd1) begin errors++; $display("FAIL raw_set got x5=%b infl=%0d want 1/1", xbusy[5], inflight); end
        checks++; if (is_ready !== 1'b0 || cause !== 3'b001) begin errors++; $display("FAIL raw_stall got rdy=%b cause=%b want 0/001", is_ready, cause); end
        wbx_v = 1; wbx_n = 5; #1;
        checks++; if (is_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle got rdy=%b want 0", is_ready); end
        step(); wbx_v = 0; #1;
        checks++; if (xbusy[5] !== 1'b0 || inflight !== 4'd0 || is_ready !== 1'b1) begin errors++; $display("FAIL raw_release got x5=%b infl=%0d rdy=%b want 0/0/1", xbusy[5], inflight, is_ready); end
        step();
        op(0, 0, 6, 0, 0, 0, 3'b000, 0); #1;
        checks++; if (is_ready !== 1'b0 || cause !== 3'b010) begin errors++; $display("FAIL waw_stall got rdy=%b cause=%b want 0/010", is_ready, cause); end
        op(0, 0, 0, 0, 0, 6, 3'b100, 0); #1;
        checks++; if (is_ready !== 1'b1) begin errors++; $display("FAIL fp_no_alias got rdy=%b want 1", is_ready); end
        do_flush();
    endtask

    task automatic test_long();
        int busy_cyc;
        op(0, 0, 0, 0, 0, 3, 3'b100, 1); #1;
        checks++; if (is_ready !== 1'b1) begin errors++; $display("FAIL long_first_ready got %b want 1", is_ready); end
        step();
        op(0, 0, 0, 0, 0, 4, 3'b100, 1); #1;
        busy_cyc = 0;
        for (int i = 0; i < 30; i++) begin
            if (!long_busy) break;
            busy_cyc++;
            checks++; if (is_ready !== 1'b0 || cause !== 3'b100) begin errors++; $display("FAIL long_stall cyc %0d got rdy=%b cause=%b want 0/100", i, is_ready, cause); end
            step();
        end
        checks++; if (busy_cyc != 12) begin errors++; $display("FAIL long_busy_len got %0d want 12", busy_cyc); end
        checks++; if (is_ready !== 1'b1) begin errors++; $display("FAIL long_fall_ready got %b want 1", is_ready); end
        step(); idle_in(); #1;
        checks++; if (long_busy !== 1'b1 || fbusy[4] !== 1'b1 || fbusy[3] !== 1'b1 || inflight !== 4'd2) begin errors++; $display("FAIL long_second got lb=%b f4=%b f3=%b infl=%0d want 1/1/1/2", long_busy, fbusy[4], fbusy[3], inflight); end
        op(0, 0, 0, 0, 3, 0, 3'b010, 0); #1;
        checks++; if (is_ready !== 1'b0 || cause !== 3'b001) begin errors++; $display("FAIL fp_raw got rdy=%b cause=%b want 0/001", is_ready, cause); end
        do_flush();
    endtask

    task automatic test_inflight();
        for (int r = 1; r <= 8; r++) begin
            op(0, 0, 5'(r), 0, 0, 0, 3'b000, 0); step();
        end
        op(0, 0, 9, 0, 0, 0, 3'b000, 0); #1;
        checks++; if (inflight !== 4'd8 || is_ready !== 1'b0 || cause !== 3'b100) begin errors++; $display("FAIL full_stall got infl=%0d rdy=%b cause=%b want 8/0/100", inflight, is_ready, cause); end
        wbx_v = 1; wbx_n = 1; #1;
        checks++; if (is_ready !== 1'b0) begin errors++; $display("FAIL full_wb_cycle got rdy=%b want 0", is_ready); end
        step(); wbx_v = 0; #1;
        checks++; if (inflight !== 4'd7 || is_ready !== 1'b1) begin errors++; $display("FAIL full_freed got infl=%0d rdy=%b want 7/1", inflight, is_ready); end
        step(); idle_in(); #1;
        checks++; if (inflight !== 4'd8 || xbusy !== 32'h0000_03FC) begin errors++; $display("FAIL full_ninth got infl=%0d x=%h want 8/000003fc", inflight, xbusy); end
        do_flush();
    endtask

    task automatic test_nodest_x0();
        op(1, 2, 0, 0, 0, 0, 3'b011, 0); step();
        idle_in(); #1;
        checks++; if (inflight !== 4'd0) begin errors++; $display("FAIL nodest got infl=%0d want 0", inflight); end
        op(0, 0, 2, 0, 0, 0, 3'b000, 0); step();
        idle_in(); wbx_v = 1; wbx_n = 0; step(); wbx_v = 0; #1;
        checks++; if (inflight !== 4'd1 || xbusy !== 32'h4) begin errors++; $display("FAIL wb_x0 got infl=%0d x=%h want 1/4", inflight, xbusy); end
        do_flush();
    endtask

    task automatic test_back_to_back();
        op(0, 0, 9, 0, 0, 0, 3'b000, 0); step();
        op(0, 0, 0, 0, 0, 2, 3'b100, 0); step();
        op(0, 0, 7, 0, 0, 0, 3'b000, 0);
        wbx_v = 1; wbx_n = 9; wbf_v = 1; wbf_n = 2; #1;
        checks++; if (inflight !== 4'd2 || is_ready !== 1'b1) begin errors++; $display("FAIL b2b_pre got infl=%0d rdy=%b want 2/1", inflight, is_ready); end
        step(); idle_in(); #1;
        checks++; if (inflight !== 4'd1) begin errors++; $display("FAIL b2b_infl got %0d want 1", inflight); end
        checks++; if (xbusy[7] !== 1'b1 || xbusy[9] !== 1'b0 || fbusy[2] !== 1'b0) begin errors++; $display("FAIL b2b_maps got x7=%b x9=%b f2=%b want 1/0/0", xbusy[7], xbusy[9], fbusy[2]); end
        do_flush();
    endtask

    task automatic test_flush();
        op(0, 0, 0, 0, 0, 1, 3'b100, 1); step();
        for (int r = 1; r <= 3; r++) begin
            op(0, 0, 5'(r), 0, 0, 0, 3'b000, 0); step();
        end
        op(0, 0, 4, 0, 0, 0, 3'b000, 0); #1;
        checks++; if (inflight !== 4'd4 || long_busy !== 1'b1) begin errors++; $display("FAIL flush_pre got infl=%0d lb=%b want 4/1", inflight, long_busy); end
        flush = 1; wbx_v = 1; wbx_n = 1; #1;
        checks++; if (is_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", is_ready); end
        step(); flush = 0; idle_in(); #1;
        checks++; if (xbusy !== 32'd0 || fbusy !== 32'd0 || inflight !== 4'd0 || long_busy !== 1'b0) begin errors++; $display("FAIL flush_clear got x=%h f=%h infl=%0d lb=%b want all 0", xbusy, fbusy, inflight, long_busy); end
    endtask

    task automatic test_async_reset();
        op(0, 0, 3, 0, 0, 5, 3'b100, 1); step();
        idle_in(); step(); step();
        checks++; if (long_busy !== 1'b1 || inflight !== 4'd1) begin errors++; $display("FAIL areset_pre got lb=%b infl=%0d want 1/1", long_busy, inflight); end
        #1 rst = 1; #1;
        checks++; if (xbusy !== 32'd0 || fbusy !== 32'd0 || inflight !== 4'd0 || long_busy !== 1'b0 || cause !== 3'b000) begin errors++; $display("FAIL areset got x=%h f=%h infl=%0d lb=%b cause=%b want 0", xbusy, fbusy, inflight, long_busy, cause); end
        step(); rst = 0;
    endtask

    initial begin
        idle_in();
        #12 rst = 0;
        step();
        test_reset();
        test_raw_waw();
        test_long();
        test_inflight();
        test_nodest_x0();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
